// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - micro-op FIFO and single-issue sequencer for the register-file/ALU datapath
//
// Buffers packed micro-ops {opcode[16:15], A3[14:10], A2[9:5], A1[4:0]} in a
// DEPTH-entry circular FIFO. It issues at most one micro-op per clock while run_i
// is high, and each issued op becomes registered register-file/ALU controls.
//
// Optional feature: define ALU_SEQ_R0_GUARD_EN to suppress rf_we_o for ops with A3=0.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   instr_valid_i/instr_i/instr_ready_o   upstream micro-op handshake
//   run_i                issue enable (0 holds FIFO contents)
//   flush_i              discard all buffered micro-ops
//   rf_we_o, rf_A1_o, rf_A2_o, rf_A3_o, alu_opcode_o   registered datapath controls
//   level_o, busy_o, issued_cnt_o                      status
module alu_op_sequencer #(
  parameter int DEPTH      = 4,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  instr_valid_i,
  input  logic [16:0]           instr_i,
  output logic                  instr_ready_o,
  input  logic                  run_i,
  input  logic                  flush_i,
  output logic                  rf_we_o,
  output logic [4:0]            rf_A1_o,
  output logic [4:0]            rf_A2_o,
  output logic [4:0]            rf_A3_o,
  output logic [1:0]            alu_opcode_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  busy_o,
  output logic [15:0]           issued_cnt_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, PAUSED} state_t;

  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);

  state_t                state_q, state_d;
  logic [16:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  rf_we_q, rf_we_d;
  logic [4:0]            a1_q, a1_d, a2_q, a2_d, a3_q, a3_d;
  logic [1:0]            op_q, op_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  push, pop;
  logic [16:0]           head;

  assign head = mem_q[rd_ptr_q];

  // Ready is low during reset so that all outputs read as zero while rst_i is high.
  // No pass-through when full: only the registered level matters, not a same-cycle pop.
  assign instr_ready_o = (level_q != FULL_LVL) & ~flush_i & ~rst_i;
  assign push          = instr_valid_i & instr_ready_o;
  // state_q is non-IDLE exactly when the FIFO holds entries; flush overrides issue.
  assign pop           = (state_q != IDLE) & run_i & ~flush_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    rf_we_d  = 1'b0;
    a1_d     = a1_q;
    a2_d     = a2_q;
    a3_d     = a3_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        a1_d     = head[4:0];
        a2_d     = head[9:5];
        a3_d     = head[14:10];
        op_d     = head[16:15];
        cnt_d    = cnt_q + 16'd1;
`ifdef ALU_SEQ_R0_GUARD_EN
        rf_we_d  = (head[14:10] != 5'd0);
`else
        rf_we_d  = 1'b1;
`endif
      end
      case ({push, pop})
        2'b10:   level_d = level_q + (DEPTH_LOG2+1)'(1);
        2'b01:   level_d = level_q - (DEPTH_LOG2+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_comb begin
    state_d = IDLE;
    if (level_d != '0) state_d = run_i ? ISSUE : PAUSED;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      rf_we_q  <= 1'b0;
      a1_q     <= '0;
      a2_q     <= '0;
      a3_q     <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      rf_we_q  <= rf_we_d;
      a1_q     <= a1_d;
      a2_q     <= a2_d;
      a3_q     <= a3_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
    end
  end

  // FIFO storage needs no reset: contents are don't-care once the pointers clear.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= instr_i;
  end

  assign rf_we_o      = rf_we_q;
  assign rf_A1_o      = a1_q;
  assign rf_A2_o      = a2_q;
  assign rf_A3_o      = a3_q;
  assign alu_opcode_o = op_q;
  assign level_o      = level_q;
  assign busy_o       = (level_q != '0) | rf_we_q;
  assign issued_cnt_o = cnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard testbench for alu_op_sequencer
module tb_alu_op_sequencer;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_valid_i;
  logic [16:0] instr_i;
  logic        instr_ready_o;
  logic        run_i;
  logic        flush_i;
  logic        rf_we_o;
  logic [4:0]  rf_A1_o, rf_A2_o, rf_A3_o;
  logic [1:0]  alu_opcode_o;
  logic [2:0]  level_o;
  logic        busy_o;
  logic [15:0] issued_cnt_o;

  int errors = 0;
  int checks = 0;
  logic [16:0] exp_q[$];

  alu_op_sequencer #(.DEPTH(4), .DEPTH_LOG2(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_valid_i(instr_valid_i), .instr_i(instr_i),
    .instr_ready_o(instr_ready_o), .run_i(run_i), .flush_i(flush_i), .rf_we_o(rf_we_o),
    .rf_A1_o(rf_A1_o), .rf_A2_o(rf_A2_o), .rf_A3_o(rf_A3_o), .alu_opcode_o(alu_opcode_o),
    .level_o(level_o), .busy_o(busy_o), .issued_cnt_o(issued_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: every write-enable pulse must match the next expected micro-op.
  always @(negedge clk_i) begin
    if (rf_we_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_we: got op %0h expected no issue",
                 {alu_opcode_o, rf_A3_o, rf_A2_o, rf_A1_o});
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        if ({alu_opcode_o, rf_A3_o, rf_A2_o, rf_A1_o} !== e) begin
          errors++;
          $display("FAIL issue_fields: got %0h expected %0h",
                   {alu_opcode_o, rf_A3_o, rf_A2_o, rf_A1_o}, e);
        end
      end
    end
  end

  logic [16:0] fill_ops [5];
  logic [16:0] op;
  logic [15:0] base;

  initial begin
    rst_i = 1'b1; instr_valid_i = 1'b0; instr_i = '0; run_i = 1'b0; flush_i = 1'b0;
    #2;
    chk("rst_ready", instr_ready_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_we", rf_we_o, 0);
    chk("rst_cnt", issued_cnt_o, 0);
    chk("rst_busy", busy_o, 0);
    step(); step();
    rst_i = 1'b0;
    #1;
    chk("rel_ready", instr_ready_o, 1);

    // Single op: issue visible exactly one cycle after the accept edge.
    run_i = 1'b1;
    op = 17'b00_00011_00010_00001;
    exp_q.push_back(op);
    instr_valid_i = 1'b1; instr_i = op;
    step();
    instr_valid_i = 1'b0;
    chk("single_we_n", rf_we_o, 0);
    step();
    chk("single_we_n1", rf_we_o, 1);
    chk("single_a1", rf_A1_o, 1);
    chk("single_a2", rf_A2_o, 2);
    chk("single_a3", rf_A3_o, 3);
    chk("single_op", alu_opcode_o, 0);
    chk("single_cnt", issued_cnt_o, 1);
    step();
    chk("single_we_n2", rf_we_o, 0);
    chk("single_level", level_o, 0);

    // Reset mid-stream with 3 ops buffered.
    run_i = 1'b0;
    instr_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr_i = {2'b01, 5'(10 + i), 5'd4, 5'd5};
      step();
    end
    instr_valid_i = 1'b0;
    chk("mid_level3", level_o, 3);
    #2 rst_i = 1'b1;
    #1;
    chk("mid_rst_level", level_o, 0);
    chk("mid_rst_cnt", issued_cnt_o, 0);
    chk("mid_rst_a3", rf_A3_o, 0);
    chk("mid_rst_a1", rf_A1_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_ready", instr_ready_o, 0);
    step();
    #2 rst_i = 1'b0;
    run_i = 1'b1;
    step(); step();
    chk("mid_rel_level", level_o, 0);
    chk("mid_rel_ready", instr_ready_o, 1);
    chk("mid_rel_cnt", issued_cnt_o, 0);

    // Fill while paused, then run: four ops drain in order, fifth accepted after a pop.
    run_i = 1'b0;
    for (int i = 0; i < 5; i++) fill_ops[i] = {2'(i), 5'(20 + i), 5'(i), 5'(30 - i)};
    instr_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instr_i = fill_ops[i];
      step();
    end
    chk("fill_level4", level_o, 4);
    chk("fill_ready0", instr_ready_o, 0);
    instr_i = fill_ops[4];
    step();
    chk("fill_refused_level", level_o, 4);
    chk("fill_busy", busy_o, 1);
    for (int i = 0; i < 5; i++) exp_q.push_back(fill_ops[i]);
    run_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("drain_we%0d", i), rf_we_o, 1);
      if (i == 0) begin
        chk("drain_level_after_pop", level_o, 3);
        chk("drain_ready_after_pop", instr_ready_o, 1);
      end
      if (i == 1) begin
        instr_valid_i = 1'b0;
        chk("drain_push_pop_level", level_o, 3);
      end
    end
    step();
    chk("drain_we_end", rf_we_o, 0);
    chk("drain_level0", level_o, 0);
    chk("drain_cnt", issued_cnt_o, 5);

    // Flush with a concurrent push: everything dropped, count unchanged.
    run_i = 1'b0;
    instr_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr_i = {2'b11, 5'(7 + i), 5'd1, 5'd2};
      step();
    end
    chk("flush_pre_level", level_o, 3);
    instr_i = 17'h1ABCD;
    flush_i = 1'b1;
    #1;
    chk("flush_ready0", instr_ready_o, 0);
    step();
    flush_i = 1'b0;
    instr_valid_i = 1'b0;
    chk("flush_level", level_o, 0);
    chk("flush_cnt", issued_cnt_o, 5);
    chk("flush_busy", busy_o, 0);
    run_i = 1'b1;
    step(); step();
    chk("flush_no_we", rf_we_o, 0);
    chk("flush_cnt_after", issued_cnt_o, 5);

    // Streaming: continuous valid with run high.
    base = issued_cnt_o;
    instr_valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      op = {2'(i), 5'(i + 1), 5'(i + 2), 5'(i + 3)};
      exp_q.push_back(op);
      instr_i = op;
      step();
      chk($sformatf("stream_level%0d", i), level_o, 1);
      if (i > 0) chk($sformatf("stream_we%0d", i), rf_we_o, 1);
    end
    instr_valid_i = 1'b0;
    chk("stream_cnt19", issued_cnt_o, 32'(base) + 19);
    step();
    chk("stream_last_we", rf_we_o, 1);
    chk("stream_cnt20", issued_cnt_o, 32'(base) + 20);
    chk("stream_level0", level_o, 0);
    step();
    chk("stream_idle_we", rf_we_o, 0);

    // Register-0 destination.
    base = issued_cnt_o;
    op = {2'b10, 5'd0, 5'd7, 5'd9};
`ifndef ALU_SEQ_R0_GUARD_EN
    exp_q.push_back(op);
`endif
    instr_valid_i = 1'b1; instr_i = op;
    step();
    instr_valid_i = 1'b0;
    step();
`ifdef ALU_SEQ_R0_GUARD_EN
    chk("guard_we", rf_we_o, 0);
`else
    chk("guard_we", rf_we_o, 1);
`endif
    chk("guard_cnt", issued_cnt_o, 32'(base) + 1);
    chk("guard_a2", rf_A2_o, 7);
    chk("guard_opc", alu_opcode_o, 2);
    step();
    chk("guard_we_end", rf_we_o, 0);

    step();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
